// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   M-stage data-memory access unit of the pipeline. Issues a single-word
//   memory request for loads and stores, stalls the pipeline while it waits
//   for mem_ack, aborts with a bus error after TIMEOUT wait cycles, and
//   registers the M-stage results into the W stage. Load data is lane-selected
//   and sign- or zero-extended. Store data is replicated across the byte
//   lanes, with matching byte enables.
//
//   Memory handshake: mem_req is a combinational request that is held high
//   for as long as the M-stage inputs present an access. The memory completes
//   the access by pulsing mem_ack for one cycle, which can be the request
//   cycle itself. The transfer happens on the rising edge that ends a cycle
//   in which mem_req && mem_ack are both high. If TIMEOUT wait cycles pass
//   with no ack, mem_req is dropped and the access completes with BusErrW=1.
//
//   Optional feature macro: MAU_MISALIGN_TRAP_EN
//     When it is defined, misaligned half/word accesses are suppressed and
//     reported through MisalignW. When it is undefined, MisalignW is tied
//     low.
//
// Ports
//   CLK, RST_N           clock (rising edge), async active-low reset
//   RegWriteM..rdM       M-stage control inputs
//   ALUResultM           byte address of the access
//   PCPlus4M, PCTargetM  passed through to W
//   WriteDataM           store data
//   mem_req, mem_we      memory request / write strobe
//   mem_addr             word address (ALUResultM[ADDR_W+1:2])
//   mem_be, mem_wdata    byte enables / lane-replicated write data
//   mem_rdata, mem_ack   memory read data / completion
//   StallM               stall request to the hazard unit
//   *W                   W-stage registers
//   StateDbg             FSM state for observation (1 = WAIT)
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_W  = 30,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RegWriteM,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [2:0]        LoadControlM,
   input  logic [1:0]        StoreControlM,
   input  logic [2:0]        ResultSrcM,
   input  logic [4:0]        rdM,
   input  logic [31:0]       ALUResultM,
   input  logic [31:0]       PCPlus4M,
   input  logic [31:0]       PCTargetM,
   input  logic [31:0]       WriteDataM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              StallM,
   output logic              RegWriteW,
   output logic [2:0]        ResultSrcW,
   output logic [4:0]        rdW,
   output logic [31:0]       ALUResultW,
   output logic [31:0]       PCPlus4W,
   output logic [31:0]       PCTargetW,
   output logic [31:0]       ReadDataW,
   output logic              BusErrW,
   output logic              MisalignW,
   output logic              StateDbg
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state, stateNext;
   logic [7:0]  waitCnt, waitCntNext;
   logic [1:0]  lane;
   logic        memOp, misalign, access, timeout, busErr;
   logic [7:0]  byteVal;
   logic [15:0] halfVal;
   logic [31:0] loadData;

   assign lane  = ALUResultM[1:0];
   assign memOp = MemReadM | MemWriteM;

`ifdef MAU_MISALIGN_TRAP_EN
   logic isHalf, isWord;
   always_comb begin
      isHalf = MemWriteM ? (StoreControlM == 2'b01) : (LoadControlM[1:0] == 2'b01);
      isWord = MemWriteM ? (StoreControlM == 2'b10) : (LoadControlM[1:0] == 2'b10);
   end
   assign misalign = memOp & ((isHalf & lane[0]) | (isWord & (lane != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   assign access  = memOp & ~misalign;
   assign timeout = (state == WAIT) && (waitCnt == TIMEOUT_CNT);
   assign busErr  = access & timeout;
   assign StallM  = access & ~mem_ack & ~timeout;
   assign mem_req = access & ~timeout;
   assign mem_we  = MemWriteM;
   assign mem_addr = ALUResultM[ADDR_W+1:2];
   assign StateDbg = (state == WAIT);

   // The counter counts elapsed wait cycles, including the first (IDLE)
   // cycle of the access. It therefore enters WAIT already at 1, and
   // TIMEOUT stalled cycles pass before the abort.
   always_comb begin
      stateNext   = state;
      waitCntNext = '0;
      case (state)
         IDLE: begin
            if (access & ~mem_ack) begin
               stateNext   = WAIT;
               waitCntNext = 8'd1;
            end
         end
         WAIT: begin
            if (mem_ack | timeout | ~access) begin
               stateNext = IDLE;
            end else begin
               waitCntNext = waitCnt + 8'd1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         waitCnt <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
      end
   end

   // Store byte enables and lane-replicated write data.
   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = WriteDataM;
      if (access) begin
         if (MemWriteM) begin
            case (StoreControlM)
               2'b00: begin
                  mem_be    = 4'b0001 << lane;
                  mem_wdata = {4{WriteDataM[7:0]}};
               end
               2'b01: begin
                  mem_be    = 4'b0011 << {lane[1], 1'b0};
                  mem_wdata = {2{WriteDataM[15:0]}};
               end
               2'b10:   mem_be = 4'b1111;
               default: mem_be = 4'b0000;
            endcase
         end else begin
            mem_be = 4'b1111;
         end
      end
   end

   // Load lane selection and extension.
   always_comb begin
      case (lane)
         2'd0:    byteVal = mem_rdata[7:0];
         2'd1:    byteVal = mem_rdata[15:8];
         2'd2:    byteVal = mem_rdata[23:16];
         default: byteVal = mem_rdata[31:24];
      endcase
      halfVal = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (LoadControlM)
         3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
         3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
         3'b010:  loadData = mem_rdata;
         3'b100:  loadData = {24'd0, byteVal};
         3'b101:  loadData = {16'd0, halfVal};
         default: loadData = '0;
      endcase
   end

   // W-stage registers: a bubble while stalled, otherwise capture M.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         rdW        <= '0;
         ALUResultW <= '0;
         PCPlus4W   <= '0;
         PCTargetW  <= '0;
         ReadDataW  <= '0;
         BusErrW    <= 1'b0;
         MisalignW  <= 1'b0;
      end else if (StallM) begin
         RegWriteW <= 1'b0;
         rdW       <= '0;
         BusErrW   <= 1'b0;
         MisalignW <= 1'b0;
      end else begin
         RegWriteW  <= RegWriteM & ~busErr & ~misalign;
         ResultSrcW <= ResultSrcM;
         rdW        <= rdM;
         ALUResultW <= ALUResultM;
         PCPlus4W   <= PCPlus4M;
         PCTargetW  <= PCTargetM;
         ReadDataW  <= (MemReadM & access & mem_ack) ? loadData : '0;
         BusErrW    <= busErr;
         MisalignW  <= misalign;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized
// transactions, checked against a behavioural model of the access rules.
module tb_mem_access_unit;
  localparam int ADDR_W  = 30;
  localparam int TIMEOUT = 15;

  logic        CLK, RST_N;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [2:0]  LoadControlM, ResultSrcM;
  logic [1:0]  StoreControlM;
  logic [4:0]  rdM;
  logic [31:0] ALUResultM, PCPlus4M, PCTargetM, WriteDataM;
  logic        mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        StallM, RegWriteW, BusErrW, MisalignW, StateDbg;
  logic [2:0]  ResultSrcW;
  logic [4:0]  rdW;
  logic [31:0] ALUResultW, PCPlus4W, PCTargetW, ReadDataW;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .LoadControlM(LoadControlM), .StoreControlM(StoreControlM),
    .ResultSrcM(ResultSrcM), .rdM(rdM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .PCTargetM(PCTargetM),
    .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .rdW(rdW),
    .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .PCTargetW(PCTargetW),
    .ReadDataW(ReadDataW), .BusErrW(BusErrW), .MisalignW(MisalignW),
    .StateDbg(StateDbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int access_size(input int kind, input logic [2:0] lc, input logic [1:0] sc);
    int code;
    code = (kind == 2) ? int'(sc) : int'(lc[1:0]);
    if (code == 1) return 2;
    if (code == 2) return 4;
    return 1;
  endfunction

  function automatic logic ref_misalign(input int kind, input int size, input logic [31:0] alu);
`ifdef MAU_MISALIGN_TRAP_EN
    return (kind != 0) && ((alu % size) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_be(input int kind, input int size, input logic [31:0] alu);
    logic [3:0] be;
    int lo;
    be = 4'h0;
    if (kind == 1) return 4'hf;
    if (kind != 2) return 4'h0;
    lo = (int'(alu % 4) / size) * size;
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + size) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] wd);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] lc, input logic [31:0] alu, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * (alu % 4))) & 32'hff;
    h = (d >> (16 * ((alu % 4) / 2))) & 32'hffff;
    case (lc)
      3'd0:    return b[7]  ? (b | 32'hffffff00) : b;
      3'd1:    return h[15] ? (h | 32'hffff0000) : h;
      3'd2:    return d;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // kind: 0 none, 1 load, 2 store. Called at a falling edge; returns at one.
  task automatic run_txn(input int kind, input logic [31:0] alu, input logic [2:0] lc,
                         input logic [1:0] sc, input logic [31:0] wd, input logic [31:0] rdata,
                         input bit has_ack, input int delay);
    int size, done_cyc, stalls;
    logic mis, acc, bus, reg_we, finished;
    logic [4:0] rd;
    logic [2:0] rsrc;
    logic [31:0] pc4, pct;
    reg_we = 1'($urandom_range(0, 1));
    rd = 5'($urandom); rsrc = 3'($urandom); pc4 = $urandom; pct = $urandom;
    RegWriteM = reg_we; rdM = rd; ResultSrcM = rsrc; PCPlus4M = pc4; PCTargetM = pct;
    MemReadM = (kind == 1); MemWriteM = (kind == 2);
    LoadControlM = lc; StoreControlM = sc; ALUResultM = alu; WriteDataM = wd;
    mem_rdata = rdata;

    size = access_size(kind, lc, sc);
    mis = ref_misalign(kind, size, alu);
    acc = (kind != 0) && !mis;
    done_cyc = !acc ? 0 : (has_ack ? delay : TIMEOUT);
    bus = acc && !has_ack;
    if (kind == 1 && acc && has_ack) exp_q.push_back(ref_load(lc, alu, rdata));

    stalls = 0;
    finished = 1'b0;
    for (int k = 0; k <= TIMEOUT + 4; k++) begin
      mem_ack = has_ack && (k == delay);
      #1;
      if (k == 0) begin
        check_val("mem_req", 32'(mem_req), 32'(acc));
        check_val("mem_be", 32'(mem_be), 32'(acc ? ref_be(kind, size, alu) : 4'h0));
        if (acc) begin
          check_val("mem_we", 32'(mem_we), 32'(kind == 2));
          check_val("mem_addr", 32'(mem_addr), alu >> 2);
          if (kind == 2) check_val("mem_wdata", mem_wdata, ref_wdata(size, wd));
        end
      end
      if (!StallM) begin
        if (bus) check_val("req_drop_on_timeout", 32'(mem_req), 32'h0);
        @(posedge CLK); #1;
        check_val("RegWriteW", 32'(RegWriteW), 32'(reg_we && !bus && !mis));
        check_val("rdW", 32'(rdW), 32'(rd));
        check_val("ResultSrcW", 32'(ResultSrcW), 32'(rsrc));
        check_val("ALUResultW", ALUResultW, alu);
        check_val("PCPlus4W", PCPlus4W, pc4);
        check_val("PCTargetW", PCTargetW, pct);
        check_val("BusErrW", 32'(BusErrW), 32'(bus));
        check_val("MisalignW", 32'(MisalignW), 32'(mis));
        check_val("state_idle", 32'(StateDbg), 32'h0);
        if (exp_q.size() > 0) check_val("ReadDataW", ReadDataW, exp_q.pop_front());
        finished = 1'b1;
        break;
      end
      stalls++;
      check_val("req_held", 32'(mem_req), 32'h1);
      @(posedge CLK); #1;
      check_val("bubble_regwrite", 32'(RegWriteW), 32'h0);
      check_val("bubble_rd", 32'(rdW), 32'h0);
      check_val("bubble_buserr", 32'(BusErrW), 32'h0);
      @(negedge CLK);
    end
    if (!finished) check_val("txn_complete", 32'h0, 32'h1);
    check_val("stall_cycles", 32'(stalls), 32'(done_cyc));
    mem_ack = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] lc_tab[6];
    lc_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    RST_N = 1'b0;
    RegWriteM = 0; MemReadM = 0; MemWriteM = 0; LoadControlM = 0; StoreControlM = 0;
    ResultSrcM = 0; rdM = 0; ALUResultM = 0; PCPlus4M = 0; PCTargetM = 0; WriteDataM = 0;
    mem_rdata = 0; mem_ack = 0;
    #12;
    check_val("rst_RegWriteW", 32'(RegWriteW), 32'h0);
    check_val("rst_ALUResultW", ALUResultW, 32'h0);
    check_val("rst_ReadDataW", ReadDataW, 32'h0);
    check_val("rst_BusErrW", 32'(BusErrW), 32'h0);
    check_val("rst_state", 32'(StateDbg), 32'h0);
    check_val("rst_stall", 32'(StallM), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Zero-wait LW, slow LB / LBU, SB / SH lanes
    run_txn(1, 32'h100, 3'd2, 2'd0, 32'h0, 32'hDEADBEEF, 1'b1, 0);
    run_txn(1, 32'h103, 3'd0, 2'd0, 32'h0, 32'h80123456, 1'b1, 2);
    run_txn(1, 32'h103, 3'd4, 2'd0, 32'h0, 32'h80123456, 1'b1, 2);
    run_txn(2, 32'h102, 3'd0, 2'd0, 32'h000000AB, 32'h0, 1'b1, 0);
    run_txn(2, 32'h102, 3'd0, 2'd1, 32'h00001234, 32'h0, 1'b1, 1);
    // No ack: abort after TIMEOUT wait cycles
    run_txn(1, 32'h200, 3'd2, 2'd0, 32'h0, 32'h12345678, 1'b0, 0);
    // Misaligned word load (trapped only when the feature is enabled)
    run_txn(1, 32'h102, 3'd2, 2'd0, 32'h0, 32'hCAFEF00D, 1'b1, 0);

    // Late ack with no access is ignored
    ALUResultM = 32'h12345670; PCPlus4M = 32'h44; mem_ack = 1'b1;
    #1;
    check_val("late_ack_stall", 32'(StallM), 32'h0);
    check_val("late_ack_req", 32'(mem_req), 32'h0);
    @(posedge CLK); #1;
    check_val("late_ack_state", 32'(StateDbg), 32'h0);
    check_val("late_ack_buserr", 32'(BusErrW), 32'h0);
    mem_ack = 1'b0;
    @(negedge CLK);

    // Reset while waiting clears W immediately and restarts the counter
    MemReadM = 1'b1; LoadControlM = 3'd2; ALUResultM = 32'h300;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    check_val("pre_rst_wait", 32'(StateDbg), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check_val("async_rst_state", 32'(StateDbg), 32'h0);
    check_val("async_rst_ALUResultW", ALUResultW, 32'h0);
    check_val("async_rst_PCPlus4W", PCPlus4W, 32'h0);
    MemReadM = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    run_txn(1, 32'h304, 3'd2, 2'd0, 32'h0, 32'h0, 1'b0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int kind, delay;
      bit has_ack;
      kind = $urandom_range(0, 2);
      has_ack = ($urandom_range(0, 7) != 0);
      delay = $urandom_range(0, 4);
      run_txn(kind, $urandom, lc_tab[$urandom_range(0, 5)], 2'($urandom_range(0, 2)),
              $urandom, $urandom, has_ack, delay);
    end

    check_val("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
